// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences
// fetch/decode/execute/memory/writeback and drives every datapath enable.
module mc_main_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] alu_ct_op,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       illegal_seen
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddiu = 6'b001001;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StJEx     = 4'd9,
        StAddiEx  = 4'd10,
        StAddiWb  = 4'd11
    } state_e;

    state_e state_q, state_d;
    logic   illegal_seen_q, illegal_seen_d;

    // State and sticky-illegal registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StFetch;
            illegal_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            illegal_seen_q <= illegal_seen_d;
        end
    end

    // Next-state and output decode; everything is held at 0 while in reset.
    always_comb begin
        state_d        = StFetch;
        pc_write       = 1'b0;
        pc_write_cond  = 1'b0;
        i_or_d         = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        mem_to_reg     = 1'b0;
        reg_dst        = 1'b0;
        reg_write      = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        pc_source      = 2'b00;
        alu_ct_op      = 2'b00;
        illegal_op     = 1'b0;
        state          = 4'd0;
        illegal_seen   = 1'b0;
        illegal_seen_d = illegal_seen_q;
        if (rst) begin
            state        = state_q;
            illegal_seen = illegal_seen_q;
            case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    state_d   = mem_ready ? StDecode : StFetch;
                end
                StDecode: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OpLw, OpSw: state_d = StMemAdr;
                        OpRtype:    state_d = StRtypeEx;
                        OpBeq:      state_d = StBeqEx;
                        OpJ:        state_d = StJEx;
                        OpAddiu:    state_d = StAddiEx;
                        default: begin
                            illegal_op = 1'b1;
                            state_d    = StFetch;
                        end
                    endcase
                end
                StMemAdr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    state_d  = mem_ready ? StMemWb : StMemRd;
                end
                StMemWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    state_d   = mem_ready ? StFetch : StMemWr;
                end
                StRtypeEx: begin
                    alu_src_a = 1'b1;
                    alu_ct_op = 2'b10;
                    state_d   = StRtypeWb;
                end
                StRtypeWb: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                StBeqEx: begin
                    alu_src_a     = 1'b1;
                    alu_ct_op     = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                StJEx: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                StAddiEx: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = StAddiWb;
                end
                StAddiWb: begin
                    reg_write = 1'b1;
                end
                // Unused codes 12-15 drive nothing and recover to fetch.
                default: state_d = StFetch;
            endcase
            illegal_seen_d = illegal_seen_q | illegal_op;
        end
    end

endmodule
